tp84_snd_cmd_tx: RTL and testbench

TP84_SND_CMD_TX -- requirements
Module: tp84_snd_cmd_tx

---
 rtl/tp84_snd_cmd_tx_if.sv | 23 ++
 rtl/tp84_snd_cmd_tx.sv | 136 +++++++++++++
 tb/tb_tp84_snd_cmd_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tp84_snd_cmd_tx_if.sv
// Command-side bus of the sound command transmitter: CPU enqueue port,
// status flags and the latch/IRQ lines towards the sound board.
interface tp84_snd_cmd_tx_if;
  logic       cmd_wr;
  logic [7:0] cmd_data;
  logic       ovf_clr;
  logic [7:0] cpubrd_Dout;
  logic       sound_data;
  logic       sound_on;
  logic       cmd_full;
  logic       busy;
  logic       ovf;

  modport master (
    output cmd_wr, cmd_data, ovf_clr,
    input  cpubrd_Dout, sound_data, sound_on, cmd_full, busy, ovf
  );

  modport slave (
    input  cmd_wr, cmd_data, ovf_clr,
    output cpubrd_Dout, sound_data, sound_on, cmd_full, busy, ovf
  );
endinterface

// File: rtl/tp84_snd_cmd_tx.sv
// Queues sound command bytes and hands each one to the sound board as
// data setup, latch strobe, IRQ pulse and a service gap.
module tp84_snd_cmd_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned GAP_CYC   = 4096
) (
  input logic             clk_49m,
  input logic             reset,
  tp84_snd_cmd_tx_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, LATCH, IRQ, GAP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          pop, push, drop;
  logic [7:0]    dout_q;
  logic          sd_q, so_q, full_q, ovf_q;

  // A full FIFO still accepts a write when the head leaves at the same edge.
  assign pop  = (state == IDLE) && (count != '0);
  assign push = bus.cmd_wr && ((count != FULL_CNT) || pop);
  assign drop = bus.cmd_wr && !push;

  always_comb begin
    count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk_49m) begin
    if (push) mem[wr_ptr] <= bus.cmd_data;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Each timed state is loaded with length-1 and exits on the edge where cnt is 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = SETUP;
          cnt_nxt   = 16'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = LATCH;
          cnt_nxt   = 16'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_nxt = IRQ;
          cnt_nxt   = 16'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      IRQ: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = 16'(GAP_CYC - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they toggle exactly on state entry.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      sd_q   <= 1'b0;
      so_q   <= 1'b0;
    end else begin
      if (pop) dout_q <= mem[rd_ptr];
      sd_q <= (state_nxt == LATCH);
      so_q <= (state_nxt == IRQ);
    end
  end

  assign bus.cpubrd_Dout = dout_q;
  assign bus.sound_data  = sd_q;
  assign bus.sound_on    = so_q;
  assign bus.cmd_full    = full_q;
  assign bus.ovf         = ovf_q;
  assign bus.busy        = (state != IDLE) || (count != '0);
endmodule

// File: tb/tb_tp84_snd_cmd_tx.sv
// Randomised and directed stimulus for tp84_snd_cmd_tx, compared every cycle
// against a queue plus transfer-phase reference model.
module tb_tp84_snd_cmd_tx;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int P     = 3;
  localparam int G     = 5;
  localparam int XLEN  = S + 2*P + G;

  logic clk_49m = 1'b0;
  logic reset   = 1'b0;
  tp84_snd_cmd_tx_if bus();

  tp84_snd_cmd_tx #(
    .DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G)
  ) dut (
    .clk_49m(clk_49m),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_49m = ~clk_49m;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: queue contents plus the edge at which the current transfer began
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_xfer;
  int         m_t0;
  int         edge_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_xfer = 1'b0;
    m_t0   = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit clr);
    bit idle, pop, drop;
    int sz0;
    idle = !m_xfer || ((edge_n - 1 - m_t0) >= XLEN);
    sz0  = q.size();
    pop  = idle && (sz0 > 0);
    if (pop) begin
      m_dout = q.pop_front();
      m_xfer = 1'b1;
      m_t0   = edge_n;
    end
    drop = 1'b0;
    if (wr) begin
      if (sz0 < DEPTH || pop) q.push_back(d);
      else drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    int k;
    bit act, e_sd, e_so;
    k    = edge_n - m_t0;
    act  = m_xfer && (k < XLEN);
    e_sd = m_xfer && (k >= S) && (k < S + P);
    e_so = m_xfer && (k >= S + P) && (k < S + 2*P);
    check_eq("dout",       32'(bus.cpubrd_Dout), 32'(m_dout));
    check_eq("sound_data", 32'(bus.sound_data),  32'(e_sd));
    check_eq("sound_on",   32'(bus.sound_on),    32'(e_so));
    check_eq("cmd_full",   32'(bus.cmd_full),    32'(q.size() == DEPTH));
    check_eq("busy",       32'(bus.busy),        32'(act || (q.size() != 0)));
    check_eq("ovf",        32'(bus.ovf),         32'(m_ovf));
    check_eq("excl",       32'(bus.sound_data & bus.sound_on), 32'd0);
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit clr);
    bus.cmd_wr   = wr;
    bus.cmd_data = d;
    bus.ovf_clr  = clr;
    @(posedge clk_49m);
    edge_n++;
    model_edge(wr, d, clr);
    #1;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int lat;
    bus.cmd_wr   = 1'b0;
    bus.cmd_data = 8'h00;
    bus.ovf_clr  = 1'b0;
    model_reset();

    // reset state
    #1;
    check_eq("rst_dout", 32'(bus.cpubrd_Dout), 32'h00);
    check_eq("rst_sd",   32'(bus.sound_data),  32'd0);
    check_eq("rst_so",   32'(bus.sound_on),    32'd0);
    check_eq("rst_busy", 32'(bus.busy),        32'd0);
    check_eq("rst_full", 32'(bus.cmd_full),    32'd0);
    check_eq("rst_ovf",  32'(bus.ovf),         32'd0);
    repeat (3) @(posedge clk_49m);
    #3 reset = 1'b1;

    // single command: first write honoured right after reset release, busy drops 14 edges later
    step(1'b1, 8'hA5, 1'b0);
    lat = 0;
    while (bus.busy && lat < 40) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    check_eq("busy_fall_edge", 32'(lat), 32'(XLEN + 1));
    idle_steps(3);

    // three back-to-back commands
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle_steps(3 * (XLEN + 1));

    // six writes: fill, overflow, clear, then keep writing into a full FIFO across pops
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), (i % 7) == 3);
    idle_steps(DEPTH * (XLEN + 1) + 5);

    // reset during LATCH with two entries queued
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    lat = 0;
    while (!bus.sound_data && lat < 20) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    check_eq("reach_latch", 32'(bus.sound_data), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("arst_sd",   32'(bus.sound_data),  32'd0);
    check_eq("arst_so",   32'(bus.sound_on),    32'd0);
    check_eq("arst_dout", 32'(bus.cpubrd_Dout), 32'h00);
    check_eq("arst_busy", 32'(bus.busy),        32'd0);
    check_eq("arst_full", 32'(bus.cmd_full),    32'd0);
    #2 reset = 1'b1;
    idle_steps(2 * (XLEN + 1));

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit wr, clr;
      wr  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(wr, 8'($urandom), clr);
    end
    idle_steps(DEPTH * (XLEN + 1) + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
